// File: rtl/ysyx_24100012_wbu.sv
// ysyx_24100012_wbu -- writeback unit in front of the register file.
//
// Takes retired ops from the EXU, waits for the LSU response on loads, then
// extends the loaded byte/half/word and drives the regfile write port from
// registers. busy_mask marks registers with a write pending or in flight so
// the IDU can stall on RAW hazards.
//
// Ports
//   clk, rst             clock (rising edge); asynchronous active-low reset
//   in_valid/in_ready    op handshake from EXU
//   in_we, in_is_load    op writes rd; op is a load
//   in_rd                destination register
//   in_load_fmt          funct3 of the load (LB/LH/LW/LBU/LHU)
//   in_addr_lo           load address bits [1:0]
//   in_alu_result        result for non-load ops
//   mem_rvalid/rready    LSU read-data handshake
//   mem_rdata            aligned 32-bit word from the LSU
//   RegWEn/RegWriteIndex/RegWriteData  registered regfile write port
//   busy_mask            bit i set while a write to xi is pending
//   dbg_state            current FSM state (IDLE=0, WAIT_MEM=1, LOAD_WB=2)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Ready depends only on the FSM state, never on valid, and a
// sender holds its payload stable while valid is high and ready is low.

module ysyx_24100012_wbu #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_LEN  = 5,
  parameter int N_REG      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_we,
  input  logic                  in_is_load,
  input  logic [INDEX_LEN-1:0]  in_rd,
  input  logic [2:0]            in_load_fmt,
  input  logic [1:0]            in_addr_lo,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  RegWEn,
  output logic [INDEX_LEN-1:0]  RegWriteIndex,
  output logic [DATA_WIDTH-1:0] RegWriteData,
  output logic [N_REG-1:0]      busy_mask,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_LOAD_WB  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Load context captured at accept time.
  logic [INDEX_LEN-1:0]  r_rd;
  logic                  r_we;
  logic [2:0]            r_fmt;
  logic [1:0]            r_addr_lo;

  logic                  w_accept;
  logic                  w_alu_we;
  logic                  w_load_we;
  logic                  w_mem_fire;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [N_REG-1:0]      w_set;
  logic [N_REG-1:0]      w_clr;
  logic [N_REG-1:0]      w_busy_nxt;

  assign dbg_state = r_state;

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    mem_rready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && in_is_load) w_state_nxt = S_WAIT_MEM;
      end
      S_WAIT_MEM: begin
        mem_rready = 1'b1;
        if (mem_rvalid) w_state_nxt = S_LOAD_WB;
      end
      S_LOAD_WB: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept   = in_valid & in_ready;
  assign w_alu_we   = in_we & (in_rd != '0);
  assign w_load_we  = r_we & (r_rd != '0);
  assign w_mem_fire = (r_state == S_WAIT_MEM) & mem_rvalid;

  // Load extraction. Halfword selection uses only addr_lo[1]; LW and the
  // unused funct3 codes return the whole word.
  always_comb begin
    w_byte = 8'h00;
    case (r_addr_lo)
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      2'd3: w_byte = mem_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_fmt)
      3'b000:  w_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      3'b100:  w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      3'b101:  w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  // busy_mask: set on accept, clear on the commit edge; set wins on overlap.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_accept && w_alu_we) w_set[in_rd] = 1'b1;
    if (RegWEn) w_clr[RegWriteIndex] = 1'b1;
    w_busy_nxt    = (busy_mask & ~w_clr) | w_set;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_rd          <= '0;
      r_we          <= 1'b0;
      r_fmt         <= 3'b000;
      r_addr_lo     <= 2'b00;
      RegWEn        <= 1'b0;
      RegWriteIndex <= '0;
      RegWriteData  <= '0;
      busy_mask     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      busy_mask <= w_busy_nxt;
      // RegWEn is a one-cycle pulse; index/data only move on a real write.
      RegWEn    <= 1'b0;
      if (w_accept && !in_is_load && w_alu_we) begin
        RegWEn        <= 1'b1;
        RegWriteIndex <= in_rd;
        RegWriteData  <= in_alu_result;
      end
      if (w_accept && in_is_load) begin
        r_rd      <= in_rd;
        r_we      <= in_we;
        r_fmt     <= in_load_fmt;
        r_addr_lo <= in_addr_lo;
      end
      // Write is registered, so it appears the cycle after mem_rvalid.
      if (w_mem_fire && w_load_we) begin
        RegWEn        <= 1'b1;
        RegWriteIndex <= r_rd;
        RegWriteData  <= w_load_data;
      end
    end
  end

endmodule
